// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings and store-unit FSM state constants.
// Imported by the store execution unit and its lane-merge helper.
package rv32i_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_MERGE = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Operands captured when a store is accepted.
    typedef struct packed {
        logic [1:0]  ea_lo;
        logic [31:0] data;
        logic [2:0]  func3;
    } store_req_t;

    function automatic logic [31:0] s_imm(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte/halfword lane insert into a RAM word; SW passes data through.
// Shared with the store-buffer path, so it carries no state.
module store_lane_merge
    import rv32i_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    input  logic [2:0]  func3,
    input  logic [1:0]  ea_lo,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (func3)
            F3_SB: begin
                case (ea_lo)
                    2'd0:    merged[7:0]   = store_data[7:0];
                    2'd1:    merged[15:8]  = store_data[7:0];
                    2'd2:    merged[23:16] = store_data[7:0];
                    default: merged[31:24] = store_data[7:0];
                endcase
            end
            F3_SH: begin
                if (ea_lo[1]) begin
                    merged[31:16] = store_data[15:0];
                end else begin
                    merged[15:0] = store_data[15:0];
                end
            end
            F3_SW:   merged = store_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/instruction_s.sv
// RV32I S-type store unit: SW writes directly (done in 2 cycles), SB/SH read-modify-write (done in 4).
// Requests arriving while busy are dropped; RAM strobes decode from the state register only.
module instruction_s
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic [31:0]       iIR,
    input  logic [31:0]       iREG_OUT1,
    input  logic [31:0]       iREG_OUT2,
    output logic [4:0]        oRS1,
    output logic [4:0]        oRS2,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oMISALIGNED,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic [31:0]       oRAM_DATA,
    input  logic [31:0]       iRAM_DATA
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    store_req_t        req_q;
    logic              mis_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;

    logic [2:0]        f3_in;
    logic [31:0]       ea_in;
    logic              mis_in;
    logic              accept;
    logic [31:0]       merged;
    logic              unused_ea_hi;

    assign oRS1  = iIR[19:15];
    assign oRS2  = iIR[24:20];
    assign f3_in = iIR[14:12];
    assign ea_in = iREG_OUT1 + s_imm(iIR);

    // Address bits above the RAM size wrap away by design.
    assign unused_ea_hi = ^ea_in[31:ADDR_W+2];

    assign mis_in = ((f3_in == F3_SH) && ea_in[0]) ||
                    ((f3_in == F3_SW) && (ea_in[1:0] != 2'b00));

    assign accept = iSTART && (state == ST_IDLE) &&
                    (iIR[6:0] == OPC_STORE) && store_f3_ok(f3_in);

    store_lane_merge u_merge (
        .old_word   (iRAM_DATA),
        .store_data (req_q.data),
        .func3      (req_q.func3),
        .ea_lo      (req_q.ea_lo),
        .merged     (merged)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (mis_in) begin
                        state_nxt = ST_DONE;
                    end else if (f3_in == F3_SW) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ:  state_nxt = ST_MERGE;
            ST_MERGE: state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state  <= ST_IDLE;
            req_q  <= '0;
            mis_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q.ea_lo <= ea_in[1:0];
                req_q.data  <= iREG_OUT2;
                req_q.func3 <= f3_in;
                mis_q       <= mis_in;
                if (!mis_in) begin
                    addr_q <= ea_in[ADDR_W+1:2];
                end
            end
            // Write data only changes on the way into WRITE, so it holds elsewhere.
            if (accept && !mis_in && (f3_in == F3_SW)) begin
                data_q <= iREG_OUT2;
            end else if (state == ST_MERGE) begin
                data_q <= merged;
            end
        end
    end

    assign oBUSY       = (state != ST_IDLE);
    assign oDONE       = (state == ST_DONE);
    assign oMISALIGNED = (state == ST_DONE) && mis_q;
    assign oRAM_CE     = (state == ST_READ) || (state == ST_WRITE);
    assign oRAM_RD     = (state == ST_READ);
    assign oRAM_WR     = (state == ST_WRITE);
    assign oRAM_ADDR   = addr_q;
    assign oRAM_DATA   = data_q;

endmodule

// File: tb/tb_instruction_s.sv
// Bench for instruction_s: behavioural word RAM plus a store reference model on byte addresses.
module tb_instruction_s;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSTART = 1'b0;
    logic [31:0] iIR = '0;
    logic [31:0] iREG_OUT1 = '0;
    logic [31:0] iREG_OUT2 = '0;
    logic [4:0]  oRS1, oRS2;
    logic        oBUSY, oDONE, oMISALIGNED;
    logic        oRAM_CE, oRAM_RD, oRAM_WR;
    logic [7:0]  oRAM_ADDR;
    logic [31:0] oRAM_DATA;
    logic [31:0] iRAM_DATA = '0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] mem [0:255];
    int          wr_events = 0;

    // observations from the last run_op
    int          obs_done_cyc, obs_n_wr, obs_n_rd, obs_n_done, obs_n_ce;
    int          obs_wr_cyc, obs_rd_cyc;
    bit          obs_mis, obs_overlap, obs_busy1;
    logic [7:0]  obs_wr_addr, obs_rd_addr;
    logic [31:0] obs_wr_data;
    logic [4:0]  obs_rs1, obs_rs2;

    instruction_s #(.ADDR_W(8)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iIR(iIR),
        .iREG_OUT1(iREG_OUT1), .iREG_OUT2(iREG_OUT2),
        .oRS1(oRS1), .oRS2(oRS2), .oBUSY(oBUSY), .oDONE(oDONE),
        .oMISALIGNED(oMISALIGNED), .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD),
        .oRAM_WR(oRAM_WR), .oRAM_ADDR(oRAM_ADDR), .oRAM_DATA(oRAM_DATA),
        .iRAM_DATA(iRAM_DATA)
    );

    always #5 iCLK = ~iCLK;

    // Synchronous RAM: read data appears the cycle after RD is sampled.
    always @(posedge iCLK) begin
        if (oRAM_CE && oRAM_RD) iRAM_DATA <= mem[oRAM_ADDR];
        if (oRAM_CE && oRAM_WR) begin
            mem[oRAM_ADDR] = oRAM_DATA;
            wr_events = wr_events + 1;
        end
    end

    function automatic logic [31:0] s_ir(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [4:0] r2);
        return {imm[11:5], r2, r1, f3, imm[4:0], opc};
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] data,
                                              input int f3, input logic [1:0] ea_lo);
        logic [31:0] mask;
        int sh;
        if (f3 == 2) return data;
        if (f3 == 0) begin
            sh = int'(ea_lo) * 8;
            mask = 32'h0000_00FF << sh;
        end else begin
            sh = (ea_lo >= 2) ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
        end
        return (old & ~mask) | ((data << sh) & mask);
    endfunction

    // Issue one request and record what the unit does over the next 8 cycles.
    task automatic run_op(input logic [31:0] ir, input logic [31:0] rs1v,
                          input logic [31:0] rs2v, input logic [8:0] restart_mask);
        obs_done_cyc = -1; obs_wr_cyc = -1; obs_rd_cyc = -1;
        obs_n_wr = 0; obs_n_rd = 0; obs_n_done = 0; obs_n_ce = 0;
        obs_mis = 0; obs_overlap = 0; obs_busy1 = 0;
        obs_wr_addr = 'x; obs_rd_addr = 'x; obs_wr_data = 'x;
        @(negedge iCLK);
        iSTART = 1'b1; iIR = ir; iREG_OUT1 = rs1v; iREG_OUT2 = rs2v;
        #1;
        obs_rs1 = oRS1; obs_rs2 = oRS2;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge iCLK);
            if (cyc == 1) obs_busy1 = oBUSY;
            if (oRAM_CE) obs_n_ce++;
            if (oRAM_RD && oRAM_WR) obs_overlap = 1;
            if (oRAM_CE && oRAM_RD) begin
                obs_n_rd++;
                if (obs_rd_cyc < 0) begin obs_rd_cyc = cyc; obs_rd_addr = oRAM_ADDR; end
            end
            if (oRAM_CE && oRAM_WR) begin
                obs_n_wr++;
                if (obs_wr_cyc < 0) begin
                    obs_wr_cyc = cyc; obs_wr_addr = oRAM_ADDR; obs_wr_data = oRAM_DATA;
                end
            end
            if (oDONE) begin
                obs_n_done++;
                if (obs_done_cyc < 0) obs_done_cyc = cyc;
            end
            if (oMISALIGNED) obs_mis = 1;
            iSTART = restart_mask[cyc];
            iIR = restart_mask[cyc] ? s_ir(7'b0100011, 3'd2, 12'h0, 5'd1, 5'd2) : $urandom;
            iREG_OUT1 = restart_mask[cyc] ? 32'h0000_0300 : $urandom;
            iREG_OUT2 = $urandom;
        end
        iSTART = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        tests_run++; if ({oBUSY, oDONE, oMISALIGNED} !== 3'b000) begin tests_failed++; $display("FAIL reset_status got %b want 000", {oBUSY, oDONE, oMISALIGNED}); end
        tests_run++; if ({oRAM_CE, oRAM_RD, oRAM_WR} !== 3'b000) begin tests_failed++; $display("FAIL reset_strobes got %b want 000", {oRAM_CE, oRAM_RD, oRAM_WR}); end
        tests_run++; if ({oRAM_ADDR, oRAM_DATA} !== 40'h0) begin tests_failed++; $display("FAIL reset_addr_data got %h want 0", {oRAM_ADDR, oRAM_DATA}); end
        iRST = 1'b0;
    endtask

    task automatic test_sw();
        mem[5] = 32'h0;
        run_op(s_ir(7'b0100011, 3'd2, 12'd4, 5'd3, 5'd7), 32'h10, 32'hDEADBEEF, '0);
        tests_run++; if (obs_wr_cyc !== 1) begin tests_failed++; $display("FAIL sw_write_cycle got %0d want 1", obs_wr_cyc); end
        tests_run++; if (obs_wr_addr !== 8'h05) begin tests_failed++; $display("FAIL sw_addr got %h want 05", obs_wr_addr); end
        tests_run++; if (obs_wr_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_data got %h want deadbeef", obs_wr_data); end
        tests_run++; if (obs_done_cyc !== 2) begin tests_failed++; $display("FAIL sw_done_cycle got %0d want 2", obs_done_cyc); end
        tests_run++; if (obs_n_rd !== 0) begin tests_failed++; $display("FAIL sw_no_read got %0d want 0", obs_n_rd); end
        tests_run++; if (obs_rs1 !== 5'd3 || obs_rs2 !== 5'd7) begin tests_failed++; $display("FAIL sw_rs_decode got %0d/%0d want 3/7", obs_rs1, obs_rs2); end
        tests_run++; if (oRAM_DATA !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_data_hold got %h want deadbeef", oRAM_DATA); end
    endtask

    task automatic test_sb();
        mem[8] = 32'h11223344;
        run_op(s_ir(7'b0100011, 3'd0, 12'd2, 5'd1, 5'd2), 32'h21, 32'h0000_00AB, '0);
        tests_run++; if (obs_rd_cyc !== 1 || obs_rd_addr !== 8'h08) begin tests_failed++; $display("FAIL sb_read got cyc %0d addr %h want 1/08", obs_rd_cyc, obs_rd_addr); end
        tests_run++; if (obs_wr_cyc !== 3 || obs_wr_data !== 32'hAB223344) begin tests_failed++; $display("FAIL sb_write got cyc %0d data %h want 3/ab223344", obs_wr_cyc, obs_wr_data); end
        tests_run++; if (obs_done_cyc !== 4) begin tests_failed++; $display("FAIL sb_done_cycle got %0d want 4", obs_done_cyc); end
        tests_run++; if (mem[8] !== 32'hAB223344) begin tests_failed++; $display("FAIL sb_ram got %h want ab223344", mem[8]); end
    endtask

    task automatic test_sh();
        mem[15] = 32'hCAFEF00D;
        run_op(s_ir(7'b0100011, 3'd1, 12'hFFE, 5'd4, 5'd5), 32'h40, 32'h0000_1234, '0);
        tests_run++; if (obs_wr_addr !== 8'h0F || obs_wr_data !== 32'h1234F00D) begin tests_failed++; $display("FAIL sh_write got addr %h data %h want 0f/1234f00d", obs_wr_addr, obs_wr_data); end
        tests_run++; if (obs_done_cyc !== 4) begin tests_failed++; $display("FAIL sh_done_cycle got %0d want 4", obs_done_cyc); end
    endtask

    task automatic test_misaligned();
        run_op(s_ir(7'b0100011, 3'd1, 12'd1, 5'd1, 5'd2), 32'h40, 32'h5555, '0);
        tests_run++; if (obs_done_cyc !== 1 || !obs_mis) begin tests_failed++; $display("FAIL mis_sh got done %0d mis %0d want 1/1", obs_done_cyc, obs_mis); end
        tests_run++; if (obs_n_ce !== 0) begin tests_failed++; $display("FAIL mis_sh_ce got %0d want 0", obs_n_ce); end
        run_op(s_ir(7'b0100011, 3'd2, 12'd2, 5'd1, 5'd2), 32'h40, 32'h5555, '0);
        tests_run++; if (obs_done_cyc !== 1 || !obs_mis) begin tests_failed++; $display("FAIL mis_sw got done %0d mis %0d want 1/1", obs_done_cyc, obs_mis); end
        tests_run++; if (obs_n_ce !== 0) begin tests_failed++; $display("FAIL mis_sw_ce got %0d want 0", obs_n_ce); end
    endtask

    task automatic test_busy_invalid();
        mem[16] = 32'hFFFF_FFFF;
        run_op(s_ir(7'b0100011, 3'd0, 12'd0, 5'd1, 5'd2), 32'h41, 32'h0000_0012, 9'b0_0000_1110);
        tests_run++; if (obs_n_wr !== 1 || obs_n_done !== 1) begin tests_failed++; $display("FAIL busy_drop got wr %0d done %0d want 1/1", obs_n_wr, obs_n_done); end
        tests_run++; if (mem[16] !== 32'hFFFF_12FF) begin tests_failed++; $display("FAIL busy_ram got %h want ffff12ff", mem[16]); end
        run_op(s_ir(7'b0000011, 3'd2, 12'd0, 5'd1, 5'd2), 32'h40, 32'h1, '0);
        tests_run++; if (obs_busy1 !== 0 || obs_n_done !== 0 || obs_n_ce !== 0) begin tests_failed++; $display("FAIL bad_opcode got busy %0d done %0d ce %0d want 0/0/0", obs_busy1, obs_n_done, obs_n_ce); end
        run_op(s_ir(7'b0100011, 3'd3, 12'd0, 5'd1, 5'd2), 32'h40, 32'h1, '0);
        tests_run++; if (obs_busy1 !== 0 || obs_n_done !== 0 || obs_n_ce !== 0) begin tests_failed++; $display("FAIL bad_func3 got busy %0d done %0d ce %0d want 0/0/0", obs_busy1, obs_n_done, obs_n_ce); end
    endtask

    task automatic test_reset_mid();
        int wr_before;
        int wr_seen;
        mem[32] = 32'h0BAD_F00D;
        wr_before = wr_events;
        wr_seen = 0;
        @(negedge iCLK);
        iSTART = 1'b1; iIR = s_ir(7'b0100011, 3'd0, 12'd0, 5'd1, 5'd2);
        iREG_OUT1 = 32'h80; iREG_OUT2 = 32'h77;
        @(negedge iCLK);
        iSTART = 1'b0;
        @(negedge iCLK);
        tests_run++; if (oBUSY !== 1'b1 || oRAM_CE !== 1'b0) begin tests_failed++; $display("FAIL mid_merge got busy %0d ce %0d want 1/0", oBUSY, oRAM_CE); end
        iRST = 1'b1;
        @(negedge iCLK);
        tests_run++; if ({oBUSY, oDONE, oMISALIGNED, oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA} !== 46'h0) begin tests_failed++; $display("FAIL mid_reset_outputs got %h want 0", {oBUSY, oDONE, oMISALIGNED, oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA}); end
        iRST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge iCLK);
            if (oRAM_WR) wr_seen++;
        end
        tests_run++; if (wr_seen !== 0 || wr_events !== wr_before) begin tests_failed++; $display("FAIL mid_no_write got %0d/%0d want 0/0", wr_seen, wr_events - wr_before); end
        tests_run++; if (mem[32] !== 32'h0BAD_F00D) begin tests_failed++; $display("FAIL mid_ram got %h want 0badf00d", mem[32]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int f3;
            logic [31:0] rs1v, rs2v, ea, old, expw;
            logic [11:0] imm;
            logic [7:0] wa;
            logic [4:0] r1, r2;
            bit mis;
            int exp_done;
            f3 = $urandom_range(0, 2);
            rs1v = $urandom; rs2v = $urandom; imm = 12'($urandom);
            r1 = 5'($urandom); r2 = 5'($urandom);
            ea = rs1v + {{20{imm[11]}}, imm};
            if ($urandom_range(0, 2) != 0) begin
                rs1v = rs1v - ((f3 == 2) ? (ea % 4) : (f3 == 1) ? (ea % 2) : 0);
                ea = rs1v + {{20{imm[11]}}, imm};
            end
            wa = 8'((ea / 4) % 256);
            mis = (f3 == 1 && (ea % 2) != 0) || (f3 == 2 && (ea % 4) != 0);
            old = $urandom;
            mem[wa] = old;
            expw = mis ? old : ref_merge(old, rs2v, f3, 2'(ea % 4));
            exp_done = mis ? 1 : (f3 == 2) ? 2 : 4;
            run_op(s_ir(7'b0100011, 3'(f3), imm, r1, r2), rs1v, rs2v, '0);
            tests_run++; if (obs_rs1 !== r1 || obs_rs2 !== r2) begin tests_failed++; $display("FAIL rnd%0d_rs got %0d/%0d want %0d/%0d", n, obs_rs1, obs_rs2, r1, r2); end
            tests_run++; if (obs_done_cyc !== exp_done || obs_mis !== mis) begin tests_failed++; $display("FAIL rnd%0d_done got %0d mis %0d want %0d/%0d", n, obs_done_cyc, obs_mis, exp_done, mis); end
            tests_run++; if (obs_n_wr !== (mis ? 0 : 1) || obs_n_rd !== ((mis || f3 == 2) ? 0 : 1) || obs_overlap) begin tests_failed++; $display("FAIL rnd%0d_strobes got wr %0d rd %0d ovl %0d", n, obs_n_wr, obs_n_rd, obs_overlap); end
            if (!mis) begin
                tests_run++; if (obs_wr_addr !== wa) begin tests_failed++; $display("FAIL rnd%0d_addr got %h want %h", n, obs_wr_addr, wa); end
            end
            tests_run++; if (mem[wa] !== expw) begin tests_failed++; $display("FAIL rnd%0d_ram got %h want %h", n, mem[wa], expw); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_sw();
        test_sb();
        test_sh();
        test_misaligned();
        test_busy_invalid();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
